cdr_loop_filter: RTL
====================

# cdr_loop_filter

Digital loop filter for the CDR, directly downstream of the early/edge/late phase detector. Consumes the detector's `up`/`down` decisions and integrates them in a bounded random-walk accumulator. Steps a multiphase clock-select index when the accumulator hits a threshold, and reports lock. The `phase_sel` output drives the phase mux that generates the detector's sampling clocks.

## Interface
- `NPHASE`, default 8: number of selectable clock phases; must be a power of two, at least 2.
- `PHASE_W`, default 3: width of `phase_sel`; equals log2(`NPHASE`).
- `THRESH`, default 4: accumulator magnitude that triggers a phase step; range 2..15.
- `ACC_W`, default 5: signed accumulator width; must hold ±`THRESH`.
- `HOLD`, default 4: cycles during which events are ignored after a step; range 1..15.
- `LOCK_N`, default 16: consecutive accepted events without a step needed to assert `locked`; range 1..255.

Ports:
- `clk`, in, 1: single block clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `up`, in, 1: phase-detector "advance" decision; asynchronous to `clk`.
- `down`, in, 1: phase-detector "retard" decision; asynchronous to `clk`.
- `phase_sel`, out, `PHASE_W`: selected clock phase index.
- `step_up`, out, 1: one-cycle pulse when `phase_sel` increments.
- `step_dn`, out, 1: one-cycle pulse when `phase_sel` decrements.
- `locked`, out, 1: loop lock indicator.

## Operation
- Input conditioning:
  - `up` and `down` each pass through a 2-flop synchronizer and then a rising-edge detector.
  - One rising edge of a detector output produces exactly one event, however long the level is held.
- Event classification, per cycle:
  - `ev_up` only: +1.
  - `ev_dn` only: −1.
  - Both, or neither: no event. Both asserted in the same cycle counts as neither.
- FSM with two states:
  - TRACK:
    - An event updates `acc`.
    - If the new value equals +`THRESH`: `phase_sel` ← `phase_sel`+1 modulo `NPHASE`, `acc` ← 0, `step_up` pulses, go to HOLD.
    - If the new value equals −`THRESH`: `phase_sel` ← `phase_sel`−1 modulo `NPHASE`, `acc` ← 0, `step_dn` pulses, go to HOLD.
  - HOLD:
    - A down-counter is loaded with `HOLD` on entry.
    - All events are discarded; `acc` stays 0.
    - Return to TRACK when the counter reaches 0.
- Wrap-around:
  - `phase_sel` at `NPHASE`−1 with an up-step becomes 0.
  - `phase_sel` at 0 with a down-step becomes `NPHASE`−1.
- Lock counter:
  - 8-bit counter that increments on each accepted (non-step) event in TRACK and saturates at `LOCK_N`.
  - `locked` = (counter == `LOCK_N`).
  - Any step clears the counter; `locked` drops on the same edge.
- Reset values:
  - `phase_sel`=0, `acc`=0, state=TRACK, hold counter=0, lock counter=0.
  - All outputs 0; synchronizer and edge-detector flops 0.
- Reset mid-operation clears everything immediately and asynchronously.
  - After deassertion, a level `up`=1 that is already high produces one event once synchronized, because the edge-detector history was reset to 0.

## Timing
- `up` sampled high at edge k:
  - Synchronizer output is high after edge k+1.
  - The event is consumed at edge k+2; `acc` and the lock counter update at edge k+2.
- Step latency:
  - The `THRESH`-th event updates `phase_sel` and asserts `step_up`/`step_dn` at edge k+2.
  - The step pulse stays high for exactly one cycle.
- HOLD spans `HOLD` full cycles; the first event that can be accepted is at edge k+2+`HOLD`+1.
- Minimum input spacing: `up`/`down` high and low phases must each last at least 2 `clk` periods to guarantee detection.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared header `cdr_defs.vh` holds:
  - FSM state encodings (TRACK=1'b0, HOLD=1'b1).
  - Default `NPHASE`/`PHASE_W`, which are also used by the phase mux and the detector bench.
- Sub-module `sync_edge`: 2-flop synchronizer plus rising-edge detector with async active-low reset. It is instantiated twice, once for `up` and once for `down`.
- Elaboration-time checks:
  - `NPHASE` == 2**`PHASE_W`.
  - 2**(`ACC_W`−1) > `THRESH`.

## Test plan
- **Reset:** assert `rst`=0 mid-stream with `acc`=3 -> all outputs 0 immediately; `phase_sel`=0 after release.
- **Up-step:** 4 isolated `up` pulses (3 cycles high, 5 low), defaults -> `phase_sel` 0→1 and a single `step_up` pulse 2 cycles after the 4th pulse is sampled; `acc`=0.
- **Down wrap:** from `phase_sel`=0, 4 `down` pulses -> `phase_sel`=7 and one `step_dn` pulse. Then 4 `up` pulses -> `phase_sel`=0.
- **Cancellation:**
  - Alternating up/down pulses ×20 -> `phase_sel` unchanged; `locked`=1 after the 16th event.
  - Then 4 `up` pulses -> `locked`=0 on the step edge.
- **Simultaneous and held inputs:**
  - `up` and `down` rising together ×10 -> no `acc` change.
  - `up` held high for 50 cycles -> exactly one event counted.
- **HOLD:** 4 `up` pulses, then 2 more `up` pulses inside the 4-cycle HOLD window -> both discarded; `acc`=0; `phase_sel`=1.

Source files
------------

// File: rtl/cdr_loop_filter_pkg.sv
// rtl/cdr_loop_filter_pkg.sv - shared types, defaults and helpers for the CDR loop filter
package cdr_loop_filter_pkg;

   // Loop filter FSM state encodings
   typedef enum logic {
      ST_TRACK = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   // Net phase-detector decision for one cycle
   typedef enum logic [1:0] {
      EV_NONE = 2'd0,
      EV_UP   = 2'd1,
      EV_DN   = 2'd2
   } ev_t;

   // Defaults shared with the phase mux and detector bench
   localparam int NPHASE_DEF  = 8;
   localparam int PHASE_W_DEF = 3;
   localparam int THRESH_DEF  = 4;
   localparam int ACC_W_DEF   = 5;
   localparam int HOLD_DEF    = 4;
   localparam int LOCK_N_DEF  = 16;

   // Coincident up/down edges cancel and count as no event
   function automatic ev_t classify(input logic ev_up, input logic ev_dn);
      ev_t ev;
      ev = EV_NONE;
      if (ev_up && !ev_dn) begin
         ev = EV_UP;
      end else if (ev_dn && !ev_up) begin
         ev = EV_DN;
      end
      return ev;
   endfunction

endpackage

// File: rtl/cdr_loop_filter_if.sv
// rtl/cdr_loop_filter_if.sv - detector decisions in, phase select and status out
interface cdr_loop_filter_if #(
   parameter int PHASE_W = 3
);
   logic               up;
   logic               down;
   logic [PHASE_W-1:0] phase_sel;
   logic               step_up;
   logic               step_dn;
   logic               locked;

   modport master (
      output up,
      output down,
      input  phase_sel,
      input  step_up,
      input  step_dn,
      input  locked
   );

   modport slave (
      input  up,
      input  down,
      output phase_sel,
      output step_up,
      output step_dn,
      output locked
   );
endinterface

// File: rtl/cdr_loop_filter_sync_edge.sv
// rtl/cdr_loop_filter_sync_edge.sv - 2-flop synchronizer with rising-edge detector
module cdr_loop_filter_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);
   logic meta;
   logic sync;
   logic hist;

   // Synchronize the async level and keep one cycle of history for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         hist <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         hist <= sync;
      end
   end

   // History resets to 0, so a level already high after reset still yields one edge
   assign pulse = sync & ~hist;

endmodule

// File: rtl/cdr_loop_filter.sv
// rtl/cdr_loop_filter.sv - bounded random-walk loop filter stepping a multiphase clock select
module cdr_loop_filter
   import cdr_loop_filter_pkg::*;
#(
   parameter int NPHASE  = NPHASE_DEF,
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int THRESH  = THRESH_DEF,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int HOLD    = HOLD_DEF,
   parameter int LOCK_N  = LOCK_N_DEF
) (
   input  logic              clk,
   input  logic              rst,
   cdr_loop_filter_if.slave  bus
);

   if (NPHASE != 2**PHASE_W) begin : g_bad_nphase
      $error("cdr_loop_filter: NPHASE must equal 2**PHASE_W");
   end
   if (2**(ACC_W-1) <= THRESH) begin : g_bad_acc_w
      $error("cdr_loop_filter: ACC_W too narrow to hold +/-THRESH");
   end

   localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
   localparam logic signed [ACC_W-1:0] THR_POS  = ACC_W'(THRESH);
   localparam logic signed [ACC_W-1:0] THR_NEG  = -THR_POS;
   localparam logic        [3:0]       HOLD_LD  = 4'(HOLD);
   localparam logic        [7:0]       LOCK_MAX = 8'(LOCK_N);

   logic ev_up;
   logic ev_dn;
   ev_t  ev;

   state_t                    state,    state_nx;
   logic signed [ACC_W-1:0]   acc,      acc_nx;
   logic signed [ACC_W-1:0]   acc_sum;
   logic        [PHASE_W-1:0] phase,    phase_nx;
   logic        [3:0]         hold_cnt, hold_nx;
   logic        [7:0]         lock_cnt, lock_nx;
   logic                      step_up_q, step_up_nx;
   logic                      step_dn_q, step_dn_nx;
   logic                      locked_q;

   cdr_loop_filter_sync_edge u_up (
      .clk   (clk),
      .rst   (rst),
      .din   (bus.up),
      .pulse (ev_up)
   );

   cdr_loop_filter_sync_edge u_dn (
      .clk   (clk),
      .rst   (rst),
      .din   (bus.down),
      .pulse (ev_dn)
   );

   assign ev = classify(ev_up, ev_dn);

   // Next-state: integrate events in TRACK, step phase at threshold, sit out HOLD
   always_comb begin
      state_nx   = state;
      acc_nx     = acc;
      acc_sum    = acc;
      phase_nx   = phase;
      hold_nx    = hold_cnt;
      lock_nx    = lock_cnt;
      step_up_nx = 1'b0;
      step_dn_nx = 1'b0;

      case (state)
         ST_TRACK: begin
            if (ev != EV_NONE) begin
               acc_sum = (ev == EV_UP) ? (acc + ACC_ONE) : (acc - ACC_ONE);
               if (acc_sum == THR_POS) begin
                  phase_nx   = phase + 1'b1;
                  acc_nx     = '0;
                  step_up_nx = 1'b1;
                  hold_nx    = HOLD_LD;
                  lock_nx    = '0;
                  state_nx   = ST_HOLD;
               end else if (acc_sum == THR_NEG) begin
                  phase_nx   = phase - 1'b1;
                  acc_nx     = '0;
                  step_dn_nx = 1'b1;
                  hold_nx    = HOLD_LD;
                  lock_nx    = '0;
                  state_nx   = ST_HOLD;
               end else begin
                  acc_nx = acc_sum;
                  if (lock_cnt != LOCK_MAX) begin
                     lock_nx = lock_cnt + 8'd1;
                  end
               end
            end
         end
         ST_HOLD: begin
            // Events are dropped here; the last HOLD cycle hands back to TRACK
            acc_nx = '0;
            if (hold_cnt <= 4'd1) begin
               hold_nx  = '0;
               state_nx = ST_TRACK;
            end else begin
               hold_nx = hold_cnt - 4'd1;
            end
         end
         default: begin
            state_nx = ST_TRACK;
            acc_nx   = '0;
            hold_nx  = '0;
         end
      endcase
   end

   // State and output registers; locked tracks the counter on the same edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_TRACK;
         acc       <= '0;
         phase     <= '0;
         hold_cnt  <= '0;
         lock_cnt  <= '0;
         step_up_q <= 1'b0;
         step_dn_q <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state     <= state_nx;
         acc       <= acc_nx;
         phase     <= phase_nx;
         hold_cnt  <= hold_nx;
         lock_cnt  <= lock_nx;
         step_up_q <= step_up_nx;
         step_dn_q <= step_dn_nx;
         locked_q  <= (lock_nx == LOCK_MAX);
      end
   end

   assign bus.phase_sel = phase;
   assign bus.step_up   = step_up_q;
   assign bus.step_dn   = step_dn_q;
   assign bus.locked    = locked_q;

endmodule
